// File: rtl/riscv_bus_pkg.sv
// Shared bus definitions for the core-side bridges: FSM state encoding and sticky error codes.
package riscv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bus_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RDWR     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter for an outstanding bus transaction; expired is high on the LIMIT-th enabled cycle
// since the last clear. Only instantiated when DATA_BRIDGE_TIMEOUT_EN is defined.
module bus_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    // count holds the number of enabled cycles already elapsed, so the LIMIT-th one sees LIMIT-1.
    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/data_mem_bridge.sv
// Turns the single-cycle core's combinational load/store into a registered bus transaction,
// stalling the core until completion. Optional abort timer: DATA_BRIDGE_TIMEOUT_EN.
module data_mem_bridge
    import riscv_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_read,
    input  logic                  core_write,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_req_write,
    output logic [ADDR_WIDTH-1:0] bus_req_addr,
    output logic [DATA_WIDTH-1:0] bus_req_wdata,
    input  logic                  bus_resp_valid,
    input  logic [DATA_WIDTH-1:0] bus_resp_rdata,
    output logic [1:0]            err_code,
    input  logic                  err_clear,
    output logic [1:0]            debug_state
);

    // Handshake: a request transfers on an edge where bus_req_valid && bus_req_ready; valid and
    // the write/addr/wdata fields stay constant until then. A response transfers on any edge with
    // bus_resp_valid while waiting for it; there is no response back-pressure.

    bus_state_t state;
    logic       req;
    logic       misaligned;
    logic       timeout_hit;
    logic [1:0] new_err;

    assign req         = core_read | core_write;
    assign misaligned  = (core_addr[1:0] != 2'b00);
    assign core_stall  = req && (state != ST_DONE);
    assign debug_state = state;

`ifdef DATA_BRIDGE_TIMEOUT_EN
    bus_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .enable ((state == ST_REQ) || (state == ST_WAIT)),
        .expired(timeout_hit)
    );
`else
    localparam logic [31:0] TIMEOUT_BITS = 32'(TIMEOUT_CYCLES);
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_BITS;
    assign timeout_hit    = 1'b0;
`endif

    // A completed handshake on the expiry cycle takes priority over the abort.
    always_comb begin
        new_err = ERR_NONE;
        if (state == ST_IDLE && req) begin
            if (misaligned) begin
                new_err = ERR_MISALIGN;
            end else if (core_read && core_write) begin
                new_err = ERR_RDWR;
            end
        end else if (timeout_hit &&
                     ((state == ST_REQ && !bus_req_ready) ||
                      (state == ST_WAIT && !bus_resp_valid))) begin
            new_err = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus_req_valid <= 1'b0;
            bus_req_write <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            core_rdata    <= '0;
            err_code      <= ERR_NONE;
        end else begin
            if (new_err != ERR_NONE && (err_code == ERR_NONE || err_clear)) begin
                err_code <= new_err;
            end else if (err_clear) begin
                err_code <= ERR_NONE;
            end

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        bus_req_addr  <= {core_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_req_wdata <= core_wdata;
                        bus_req_write <= core_write;
                        if (misaligned) begin
                            core_rdata <= '0;
                            state      <= ST_DONE;
                        end else begin
                            bus_req_valid <= 1'b1;
                            state         <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end else if (timeout_hit) begin
                        bus_req_valid <= 1'b0;
                        core_rdata    <= '0;
                        state         <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (bus_resp_valid) begin
                        if (!bus_req_write) begin
                            core_rdata <= bus_resp_rdata;
                        end
                        state <= ST_DONE;
                    end else if (timeout_hit) begin
                        core_rdata <= '0;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: directed scenarios plus randomized accesses against a
// transaction-level model (stall length from bus delays, sticky error, expected load data queue).
`timescale 1ns/1ps
module tb_data_mem_bridge;
    import riscv_bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_read;
    logic          core_write;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          bus_req_valid;
    logic          bus_req_ready;
    logic          bus_req_write;
    logic [AW-1:0] bus_req_addr;
    logic [DW-1:0] bus_req_wdata;
    logic          bus_resp_valid;
    logic [DW-1:0] bus_resp_rdata;
    logic [1:0]    err_code;
    logic          err_clear;
    logic [1:0]    debug_state;

    int checks = 0;
    int errors = 0;

    logic [1:0]    exp_err;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] exp_q[$];

    data_mem_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_read     (core_read),
        .core_write    (core_write),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_write (bus_req_write),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_resp_valid(bus_resp_valid),
        .bus_resp_rdata(bus_resp_rdata),
        .err_code      (err_code),
        .err_clear     (err_clear),
        .debug_state   (debug_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_err   = ERR_NONE;
        exp_rdata = '0;
        exp_q.delete();
        tick();
    endtask

    // ---------------- driver + model: one core access ----------------
    task automatic run_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input int rdy_dly, input int resp_dly,
                              input logic [DW-1:0] rdata, input string name);
        int            stall_n;
        int            rq_wait;
        int            rs_wait;
        int            exp_stall;
        bit            accepted;
        bit            done;
        bit            bad_field;
        bit            saw_valid;
        bit            overrun;
        logic          misal;
        logic [1:0]    new_err;
        logic [DW-1:0] want;
        logic [AW-1:0] exp_addr;

        stall_n = 0; rq_wait = 0; rs_wait = 0;
        accepted = 0; done = 0; bad_field = 0; saw_valid = 0; overrun = 0;
        misal    = (addr[1:0] != 2'b00);
        exp_addr = {addr[AW-1:2], 2'b00};
        new_err  = misal ? ERR_MISALIGN : ((rd && wr) ? ERR_RDWR : ERR_NONE);
        if (new_err != ERR_NONE && exp_err == ERR_NONE) exp_err = new_err;
        exp_stall = misal ? 1 : (3 + rdy_dly + resp_dly);
        if (misal) exp_rdata = '0;
        else if (!wr) exp_rdata = rdata;
        exp_q.push_back(exp_rdata);

        core_read = rd; core_write = wr; core_addr = addr; core_wdata = wdata;
        while (!done) begin
            #1;
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b0;
            if (!core_stall) begin
                done = 1;
            end else begin
                stall_n++;
                if (bus_req_valid) begin
                    saw_valid = 1;
                    if (bus_req_addr !== exp_addr || bus_req_wdata !== wdata || bus_req_write !== wr)
                        bad_field = 1;
                    if (rq_wait == rdy_dly) begin
                        bus_req_ready = 1'b1;
                        accepted      = 1;
                    end else begin
                        rq_wait++;
                    end
                end else if (accepted) begin
                    if (rs_wait == resp_dly) begin
                        bus_resp_valid = 1'b1;
                        bus_resp_rdata = rdata;
                    end else begin
                        rs_wait++;
                    end
                end
                if (stall_n > exp_stall + 20) begin
                    overrun = 1;
                    done    = 1;
                end else begin
                    @(posedge clk);
                end
            end
        end

        checks++;
        if (overrun) begin
            errors++;
            $display("FAIL %s stall_timeout: stalled %0d cycles, required %0d", name, stall_n, exp_stall);
            core_read = 1'b0; core_write = 1'b0;
            bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
            apply_reset();
            return;
        end
        if (stall_n !== exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d, required %0d", name, stall_n, exp_stall);
        end
        checks++;
        if (saw_valid !== !misal) begin
            errors++;
            $display("FAIL %s req_valid_seen: got %0d, required %0d", name, saw_valid, !misal);
        end
        checks++;
        if (bad_field) begin
            errors++;
            $display("FAIL %s req_fields: unstable or wrong (addr 0x%08h wr %0d), required addr 0x%08h wdata 0x%08h wr %0d",
                     name, bus_req_addr, bus_req_write, exp_addr, wdata, wr);
        end
        want = exp_q.pop_front();
        checks++;
        if (core_rdata !== want) begin
            errors++;
            $display("FAIL %s core_rdata: got 0x%08h, required 0x%08h", name, core_rdata, want);
        end
        checks++;
        if (err_code !== exp_err) begin
            errors++;
            $display("FAIL %s err_code: got %0d, required %0d", name, err_code, exp_err);
        end
        core_read = 1'b0; core_write = 1'b0;
        tick();
        checks++;
        if (debug_state !== 2'(ST_IDLE) || bus_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: state %0d valid %0d, required state %0d valid 0",
                     name, debug_state, bus_req_valid, ST_IDLE);
        end
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_err = ERR_NONE;
        checks++;
        if (err_code !== ERR_NONE) begin
            errors++;
            $display("FAIL err_clear: got %0d, required 0", err_code);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        core_read = 1'b0; core_write = 1'b0; core_addr = '0; core_wdata = '0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = '0; err_clear = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (debug_state !== 2'(ST_IDLE) || bus_req_valid !== 1'b0 || bus_req_write !== 1'b0 ||
            bus_req_addr !== '0 || bus_req_wdata !== '0 || core_rdata !== '0 ||
            err_code !== ERR_NONE || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: state %0d valid %0d write %0d addr 0x%08h wdata 0x%08h rdata 0x%08h err %0d stall %0d, required all zero",
                     debug_state, bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata,
                     core_rdata, err_code, core_stall);
        end
        core_read = 1'b1;
        #1;
        checks++;
        if (core_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_comb: got %0d, required 1", core_stall);
        end
        core_read = 1'b0;
        apply_reset();
    endtask

    task automatic test_directed();
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 0, 32'hCAFEF00D, "load_basic");
        run_access(1'b0, 1'b1, 32'h204, 32'h12345678, 5, 0, 32'h5555AAAA, "store_ready_delay");
        run_access(1'b1, 1'b0, 32'h103, 32'h0, 0, 0, 32'h77777777, "load_misaligned");
        clear_errors();
        run_access(1'b1, 1'b1, 32'h40, 32'hA5A5_0F0F, 0, 0, 32'h13579BDF, "read_write_both");
        run_access(1'b1, 1'b0, 32'h201, 32'h0, 0, 0, 32'h0, "first_error_wins");
    endtask

    task automatic test_err_priority();
        // err_code is nonzero here; a new error in the same cycle as err_clear must win.
        core_read = 1'b1; core_addr = 32'h3; err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_err   = ERR_MISALIGN;
        exp_rdata = '0;
        checks++;
        if (err_code !== ERR_MISALIGN || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_vs_new: err %0d stall %0d, required err 1 stall 0", err_code, core_stall);
        end
        core_read = 1'b0;
        tick();
        clear_errors();
    endtask

    task automatic test_spurious_resp();
        logic [1:0] err_before;
        run_access(1'b1, 1'b1, 32'h80, 32'hFEEDBEEF, 1, 2, 32'h0BAD0BAD, "rdwr_delays");
        err_before = exp_err;
        for (int i = 0; i < 3; i++) begin
            bus_resp_valid = 1'b1;
            bus_resp_rdata = $urandom;
            tick();
        end
        bus_resp_valid = 1'b0;
        checks++;
        if (core_rdata !== exp_rdata || err_code !== err_before || debug_state !== 2'(ST_IDLE) ||
            core_stall !== 1'b0) begin
            errors++;
            $display("FAIL spurious_resp: rdata 0x%08h err %0d state %0d stall %0d, required rdata 0x%08h err %0d state 0 stall 0",
                     core_rdata, err_code, debug_state, core_stall, exp_rdata, err_before);
        end
        clear_errors();
    endtask

    task automatic test_reset_mid();
        core_read = 1'b1; core_addr = 32'h88;
        tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        checks++;
        if (debug_state !== 2'(ST_WAIT)) begin
            errors++;
            $display("FAIL reset_mid_setup: state %0d, required %0d", debug_state, ST_WAIT);
        end
        reset = 1'b1;
        #1;
        exp_err = ERR_NONE; exp_rdata = '0;
        checks++;
        if (debug_state !== 2'(ST_IDLE) || bus_req_valid !== 1'b0 || core_rdata !== '0) begin
            errors++;
            $display("FAIL reset_mid_abort: state %0d valid %0d rdata 0x%08h, required 0 0 0",
                     debug_state, bus_req_valid, core_rdata);
        end
        core_read = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'hDEADC0DE;
        tick();
        bus_resp_valid = 1'b0;
        checks++;
        if (core_rdata !== '0 || debug_state !== 2'(ST_IDLE) || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL late_resp_ignored: rdata 0x%08h state %0d stall %0d, required 0 0 0",
                     core_rdata, debug_state, core_stall);
        end
    endtask

`ifdef DATA_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int  stall_n;
        bit  done;
        stall_n = 0; done = 0;
        core_write = 1'b1; core_addr = 32'h300; core_wdata = 32'h11112222;
        while (!done) begin
            #1;
            if (!core_stall || stall_n > TO + 20) done = 1;
            else begin
                stall_n++;
                @(posedge clk);
            end
        end
        if (exp_err == ERR_NONE) exp_err = ERR_TIMEOUT;
        exp_rdata = '0;
        checks++;
        if (stall_n !== TO + 1 || err_code !== exp_err || core_rdata !== '0 || bus_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: stall %0d err %0d rdata 0x%08h valid %0d, required stall %0d err %0d rdata 0 valid 0",
                     stall_n, err_code, core_rdata, bus_req_valid, TO + 1, exp_err);
        end
        core_write = 1'b0;
        tick();
        clear_errors();
    endtask
`else
    task automatic test_timeout();
        run_access(1'b0, 1'b1, 32'h300, 32'h11112222, 300, 1, 32'h0, "no_timeout_long_wait");
    endtask
`endif

    task automatic test_random();
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        int            kind;
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 5);
            rd   = (kind <= 2) || (kind == 5);
            wr   = (kind == 3) || (kind == 4) || (kind == 5);
            addr = $urandom & ~32'h3;
            if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            run_access(rd, wr, addr, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                       $urandom, "random");
            if (i % 6 == 5) clear_errors();
        end
    endtask

    initial begin
        reset = 1'b1;
        exp_err = ERR_NONE;
        exp_rdata = '0;
        test_reset();
        test_directed();
        test_err_priority();
        test_spurious_resp();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
